// File: rtl/disp_scan_n_pkg.sv
// Shared constants and helpers for multiplexed 7-segment display drivers.
// Segment patterns are active-low {g,f,e,d,c,b,a}; point is added by the decoder.
package disp_scan_n_pkg;

  localparam int unsigned MaxDigits = 32;

  localparam logic [7:0] SegBlank = 8'hFF;

  // Index 0 is the last entry of the concatenation.
  localparam logic [15:0][6:0] HexFont = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Digit index to one-hot-low anode select; callers truncate to their width.
  function automatic logic [MaxDigits-1:0] digit_sel(input logic [31:0] idx);
    return ~(MaxDigits'(1) << idx);
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex digit + decimal point to active-low 8-bit segment pattern.
module hex7seg_decode
  import disp_scan_n_pkg::*;
(
  input  logic [3:0] hex_i,
  input  logic       point_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = {~point_i, HexFont[hex_i]};
  end

endmodule

// File: rtl/disp_scan_n.sv
// Multiplexed common-anode 7-segment driver with PWM brightness, per-digit blink,
// leading-zero suppression and frame-synchronous double-buffered data loading.
module disp_scan_n
  import disp_scan_n_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_LOG2  = 17,
  parameter int unsigned BRIGHT_W   = 3,
  parameter int unsigned BLINK_LOG2 = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     les,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_blank,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            segment,
  output logic                  frame_start
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] hexs;
    logic [DIGITS-1:0]   points;
    logic [DIGITS-1:0]   les;
    logic [DIGITS-1:0]   blink;
  } frame_t;

  localparam frame_t FrameReset = '{hexs: '0, points: '0, les: '1, blink: '0};

  logic [SCAN_LOG2-1:0]  presc_q, presc_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;
  frame_t                act_q, act_d, pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_start_q, frame_start_d;

  logic                  presc_tc, boundary, commit;
  logic [4*DIGITS-1:0]   hex_sh;
  logic [DIGITS-1:0]     digit_mask;
  logic [3:0]            cur_hex;
  logic                  cur_pt, cur_le, cur_bl;
  logic [BRIGHT_W-1:0]   pwm_phase;
  logic                  blank;
  logic [7:0]            dec_seg;

  always_comb begin
    presc_tc = &presc_q;
    boundary = presc_tc && (idx_q == LastIdx);
    commit   = boundary && pend_valid_q;

    presc_d     = presc_q + SCAN_LOG2'(1);
    blink_cnt_d = blink_cnt_q + BLINK_LOG2'(1);
    idx_d       = idx_q;
    if (presc_tc) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
    end

    // Commit reads the pre-load pending copy, so a coincident load stays pending.
    act_d        = commit ? pend_q : act_q;
    pend_d       = pend_q;
    pend_valid_d = commit ? 1'b0 : pend_valid_q;
    if (load) begin
      pend_d       = '{hexs: hexs, points: points, les: les, blink: blink};
      pend_valid_d = 1'b1;
    end
    frame_start_d = commit;
  end

  always_comb begin
    // Shifted hex word: low nibble is the current digit, zero iff it and all above are 0.
    hex_sh     = act_q.hexs >> {idx_q, 2'b00};
    cur_hex    = hex_sh[3:0];
    digit_mask = DIGITS'(1) << idx_q;
    cur_pt     = |(act_q.points & digit_mask);
    cur_le     = |(act_q.les & digit_mask);
    cur_bl     = |(act_q.blink & digit_mask);
    pwm_phase  = presc_q[SCAN_LOG2-1 -: BRIGHT_W];

    blank = cur_le
         || (cur_bl && blink_cnt_q[BLINK_LOG2-1])
         || (pwm_phase > brightness)
         || (lz_blank && (idx_q != '0) && (hex_sh == '0) && !cur_pt);

    an_d  = blank ? {DIGITS{1'b1}} : DIGITS'(digit_sel(32'(idx_q)));
    seg_d = blank ? SegBlank : dec_seg;
  end

  hex7seg_decode u_decode (
    .hex_i   (cur_hex),
    .point_i (cur_pt),
    .seg_o   (dec_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      act_q         <= FrameReset;
      pend_q        <= FrameReset;
      pend_valid_q  <= 1'b0;
      an_q          <= '1;
      seg_q         <= SegBlank;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      act_q         <= act_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign segment     = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_disp_scan_n.sv
// Bench for disp_scan_n: time-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_disp_scan_n;

  localparam int unsigned DIGITS     = 4;
  localparam int unsigned SCAN_LOG2  = 4;
  localparam int unsigned BRIGHT_W   = 2;
  localparam int unsigned BLINK_LOG2 = 8;

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] hexs;
  logic [3:0]  points, les, blink;
  logic        lz_blank;
  logic [1:0]  brightness;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  segment;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int nn       = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  disp_scan_n #(
    .DIGITS     (DIGITS),
    .SCAN_LOG2  (SCAN_LOG2),
    .BRIGHT_W   (BRIGHT_W),
    .BLINK_LOG2 (BLINK_LOG2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hexs        (hexs),
    .points      (points),
    .les         (les),
    .blink       (blink),
    .lz_blank    (lz_blank),
    .brightness  (brightness),
    .load        (load),
    .an          (an),
    .segment     (segment),
    .frame_start (frame_start)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, got, exp, $time);
    end
  endtask

  // Model: t = clock edges since reset release; counters are plain arithmetic on t.
  int          t     = 0;
  logic [15:0] a_hex = '0, p_hex = '0;
  logic [3:0]  a_pt = '0, a_le = 4'hF, a_bl = '0;
  logic [3:0]  p_pt = '0, p_le = 4'hF, p_bl = '0;
  bit          p_v   = 1'b0;
  logic [3:0]  e_an  = 4'hF;
  logic [7:0]  e_seg = 8'hFF;
  logic        e_fs  = 1'b0;

  task automatic model_reset();
    t = 0;
    a_hex = '0; a_pt = '0; a_le = 4'hF; a_bl = '0;
    p_hex = '0; p_pt = '0; p_le = 4'hF; p_bl = '0; p_v = 1'b0;
    e_an = 4'hF; e_seg = 8'hFF; e_fs = 1'b0;
  endtask

  task automatic model_step();
    int          d, ph;
    bit          lit, commit, pt;
    logic [15:0] sh;
    logic [3:0]  h;
    d  = (t / 16) % 4;
    ph = (t % 16) / 4;
    sh = a_hex >> (4 * d);
    h  = sh[3:0];
    pt = a_pt[d];
    lit = !a_le[d] && !(a_bl[d] && ((t / 128) % 2 == 1)) && (ph <= int'(brightness))
          && !(lz_blank && d != 0 && !pt && sh == 16'h0);
    e_an  = 4'hF;
    e_seg = 8'hFF;
    if (lit) begin
      e_an[d] = 1'b0;
      e_seg   = {~pt, FONT[h]};
    end
    commit = (t % 64 == 63) && p_v;
    if (commit) begin
      a_hex = p_hex; a_pt = p_pt; a_le = p_le; a_bl = p_bl; p_v = 1'b0;
    end
    if (load) begin
      p_hex = hexs; p_pt = points; p_le = les; p_bl = blink; p_v = 1'b1;
    end
    e_fs = commit;
    t++;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_an", 32'(an), 32'(e_an));
        check("model_segment", 32'(segment), 32'(e_seg));
        check("model_frame_start", 32'(frame_start), 32'(e_fs));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    nn += n;
  endtask

  task automatic wait_nn(input int target);
    if (target > nn) step(target - nn);
  endtask

  task automatic load_vec(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l,
                          input logic [3:0] b);
    hexs = h; points = p; les = l; blink = b; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic count_lit(input int n, output int c);
    c = 0;
    repeat (n) begin
      step(1);
      if (an != 4'hF) c++;
    end
  endtask

  task automatic check_digit(input string name, input logic [3:0] exp_an,
                             input logic [7:0] exp_seg);
    check({name, "_an"}, 32'(an), 32'(exp_an));
    check({name, "_seg"}, 32'(segment), 32'(exp_seg));
  endtask

  initial begin
    int c;
    hexs = '0; points = '0; les = 4'hF; blink = '0;
    lz_blank = 1'b0; brightness = 2'd3; load = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(segment), 32'hFF);
    check("reset_fs", 32'(frame_start), 32'h0);

    rst = 1'b1; chk_en = 1'b1; nn = 0;
    load_vec(16'h1234, 4'h0, 4'h0, 4'h0);
    wait_nn(63); check("pre_boundary_an", 32'(an), 32'hF);
    wait_nn(64); check("first_fs", 32'(frame_start), 32'h1);
    check("boundary_an", 32'(an), 32'hF);
    wait_nn(65); check_digit("d0_first", 4'b1110, 8'h99);
    check("fs_single", 32'(frame_start), 32'h0);
    wait_nn(81);  check_digit("d1_scan", 4'b1101, 8'hB0);
    wait_nn(97);  check_digit("d2_scan", 4'b1011, 8'hA4);
    wait_nn(113); check_digit("d3_scan", 4'b0111, 8'hF9);

    wait_nn(128); brightness = 2'd0;
    count_lit(16, c); check("lit_bright0", 32'(c), 32'd4);
    brightness = 2'd2;
    count_lit(16, c); check("lit_bright2", 32'(c), 32'd12);

    brightness = 2'd3; lz_blank = 1'b1;
    load_vec(16'h0050, 4'h0, 4'h0, 4'h0);
    wait_nn(193); check_digit("lz_d0", 4'b1110, 8'hC0);
    wait_nn(209); check_digit("lz_d1", 4'b1101, 8'h92);
    wait_nn(225); check_digit("lz_d2", 4'hF, 8'hFF);
    wait_nn(241); check_digit("lz_d3", 4'hF, 8'hFF);
    wait_nn(256); load_vec(16'h0000, 4'h0, 4'h0, 4'h0);
    wait_nn(321); check_digit("lz0_d0", 4'b1110, 8'hC0);
    wait_nn(337); check_digit("lz0_d1", 4'hF, 8'hFF);
    wait_nn(384); load_vec(16'h0000, 4'b0100, 4'h0, 4'h0);
    wait_nn(465); check_digit("lzpt_d1", 4'hF, 8'hFF);
    wait_nn(481); check_digit("lzpt_d2", 4'b1011, 8'h40);
    wait_nn(497); check_digit("lzpt_d3", 4'hF, 8'hFF);

    wait_nn(512); lz_blank = 1'b0;
    load_vec(16'h1234, 4'h0, 4'h0, 4'b0001);
    wait_nn(577); check_digit("blink_on", 4'b1110, 8'h99);
    wait_nn(641); check_digit("blink_off", 4'hF, 8'hFF);
    wait_nn(657); check_digit("blink_other", 4'b1101, 8'hB0);
    wait_nn(769); check_digit("blink_on2", 4'b1110, 8'h99);

    wait_nn(784); load_vec(16'hAAAA, 4'h0, 4'h0, 4'h0);
    wait_nn(786); load_vec(16'hBBBB, 4'h0, 4'h0, 4'h0);
    wait_nn(832); check("last_wins_fs", 32'(frame_start), 32'h1);
    wait_nn(833); check_digit("last_wins_d0", 4'b1110, 8'h83);
    wait_nn(849); check_digit("last_wins_d1", 4'b1101, 8'h83);

    wait_nn(880); load_vec(16'hDDDD, 4'h0, 4'h0, 4'h0);
    wait_nn(895); load_vec(16'hCCCC, 4'h0, 4'h0, 4'h0);
    check("coinc_fs", 32'(frame_start), 32'h1);
    wait_nn(897); check_digit("coinc_old", 4'b1110, 8'hA1);
    wait_nn(960); check("coinc_next_fs", 32'(frame_start), 32'h1);
    wait_nn(961); check_digit("coinc_new", 4'b1110, 8'hC6);
    wait_nn(1024); check("idle_fs", 32'(frame_start), 32'h0);

    wait_nn(1030); check("pre_reset_an", 32'(an), 32'b1110);
    #2 rst = 1'b0;
    #1;
    check("async_reset_an", 32'(an), 32'hF);
    check("async_reset_seg", 32'(segment), 32'hFF);
    check("async_reset_fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
